tlul_sram_slave: RTL and testbench

//  TL-UL responder terminating the interconnect slave port (slave_a_* in, slave_d_* out). Word-addressed

---
 rtl/tlul_pkg.sv | 17 +
 rtl/tlul_sram_slave_mem.sv | 35 +++
 rtl/tlul_sram_slave.sv | 174 +++++++++++++++++
 tb/tb_tlul_sram_slave.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// Shared TL-UL opcode constants and responder state encoding for tlul_sram_slave.
`timescale 1ns/1ps
package tlul_pkg;

  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_GET         = 3'd4;
  localparam logic [2:0] TL_ACK         = 3'd0;
  localparam logic [2:0] TL_ACK_DATA    = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

endpackage

// File: rtl/tlul_sram_slave_mem.sv
// Single-port byte-enable RAM with a registered read port; contents are never reset.
`timescale 1ns/1ps
module tlul_sram_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  localparam int MASK_WIDTH = DATA_WIDTH / 8,
  localparam int IDX_W      = $clog2(MEM_WORDS)
) (
  input  logic                  i_clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [MASK_WIDTH-1:0] i_be,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Read data only updates on an enabled access so it holds through the response phase.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < MASK_WIDTH; b++) begin
          if (i_be[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tlul_sram_slave.sv
// TL-UL responder over a word-addressed byte-enable SRAM, one transaction outstanding,
// with a programmable access delay and legality checking reported through d_error.
`timescale 1ns/1ps
module tlul_sram_slave
  import tlul_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    OPCODE_WIDTH = 3,
  parameter int                    PARAM_WIDTH  = 3,
  parameter int                    SIZE_WIDTH   = 3,
  parameter int                    SRC_WIDTH    = 1,
  parameter int                    SINK_WIDTH   = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_1000,
  parameter int                    MEM_WORDS    = 1024,
  parameter int                    WAIT_CYCLES  = 2,
  localparam int                   MASK_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                    clk_24,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [OPCODE_WIDTH-1:0] a_opcode,
  input  logic [PARAM_WIDTH-1:0]  a_param,
  input  logic [SIZE_WIDTH-1:0]   a_size,
  input  logic [SRC_WIDTH-1:0]    a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [MASK_WIDTH-1:0]   a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [OPCODE_WIDTH-1:0] d_opcode,
  output logic [PARAM_WIDTH-1:0]  d_param,
  output logic [SIZE_WIDTH-1:0]   d_size,
  output logic [SRC_WIDTH-1:0]    d_source,
  output logic [SINK_WIDTH-1:0]   d_sink,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_error
);

  localparam int LANE_W = $clog2(MASK_WIDTH);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_e                  r_state;
  state_e                  w_nextState;
  logic [CNT_W-1:0]        r_waitCnt;
  logic [OPCODE_WIDTH-1:0] r_opcode;
  logic [SIZE_WIDTH-1:0]   r_size;
  logic [SRC_WIDTH-1:0]    r_source;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [MASK_WIDTH-1:0]   r_mask;
  logic [DATA_WIDTH-1:0]   r_data;

  logic                    w_aFire;
  logic                    w_accessDone;
  logic [ADDR_WIDTH-1:0]   w_offset;
  logic [IDX_W-1:0]        w_idx;
  logic [MASK_WIDTH-1:0]   w_laneMask;
  logic                    w_isGet;
  logic                    w_opLegal;
  logic                    w_sizeLegal;
  logic                    w_aligned;
  logic                    w_inRange;
  logic                    w_maskLegal;
  logic                    w_legal;
  logic                    w_memEn;
  logic                    w_memWe;
  logic [DATA_WIDTH-1:0]   w_rdata;
  logic                    w_unused;

  assign w_aFire      = a_valid && (r_state == ST_IDLE);
  assign w_accessDone = (r_state == ST_ACCESS) && (r_waitCnt == CNT_W'(WAIT_CYCLES));

  always_ff @(posedge clk_24) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (a_valid)      w_nextState = ST_ACCESS;
      ST_ACCESS: if (w_accessDone) w_nextState = ST_RESP;
      ST_RESP:   if (d_ready)      w_nextState = ST_IDLE;
      default:                     w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_24) begin
    if (reset)                                 r_waitCnt <= '0;
    else if (r_state == ST_ACCESS && !w_accessDone) r_waitCnt <= r_waitCnt + 1'b1;
    else                                       r_waitCnt <= '0;
  end

  always_ff @(posedge clk_24) begin
    if (reset) begin
      r_opcode <= '0;
      r_size   <= '0;
      r_source <= '0;
      r_addr   <= '0;
      r_mask   <= '0;
      r_data   <= '0;
    end else if (w_aFire) begin
      r_opcode <= a_opcode;
      r_size   <= a_size;
      r_source <= a_source;
      r_addr   <= a_address;
      r_mask   <= a_mask;
      r_data   <= a_data;
    end
  end

  // A byte belongs to the addressed lane group when it shares the address bits above the size.
  always_comb begin
    w_laneMask = '0;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      w_laneMask[i] = ((i >> r_size) == (int'(r_addr[LANE_W-1:0]) >> r_size));
    end
  end

  assign w_offset    = r_addr - BASE_ADDR;
  assign w_idx       = w_offset[IDX_W+1:2];
  assign w_isGet     = (r_opcode == OPCODE_WIDTH'(TL_GET));
  assign w_opLegal   = w_isGet || (r_opcode == OPCODE_WIDTH'(TL_PUT_FULL))
                     || (r_opcode == OPCODE_WIDTH'(TL_PUT_PARTIAL));
  assign w_sizeLegal = (r_size <= SIZE_WIDTH'(LANE_W));
  assign w_aligned   = ((int'(r_addr[LANE_W-1:0]) & ((1 << r_size) - 1)) == 0);
  assign w_inRange   = (r_addr >= BASE_ADDR) && (w_offset < ADDR_WIDTH'(4 * MEM_WORDS));
  assign w_maskLegal = (r_opcode == OPCODE_WIDTH'(TL_PUT_FULL))    ? (r_mask == w_laneMask) :
                       (r_opcode == OPCODE_WIDTH'(TL_PUT_PARTIAL)) ? ((r_mask & ~w_laneMask) == '0) :
                       1'b1;
  assign w_legal     = w_opLegal && w_sizeLegal && w_aligned && w_inRange && w_maskLegal;

  // Commit happens on the ACCESS->RESP edge; a concurrent reset discards it.
  assign w_memEn = w_accessDone && !reset;
  assign w_memWe = w_legal && !w_isGet;

  tlul_sram_slave_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_mem (
    .i_clk   (clk_24),
    .i_en    (w_memEn),
    .i_we    (w_memWe),
    .i_be    (r_mask),
    .i_idx   (w_idx),
    .i_wdata (r_data),
    .o_rdata (w_rdata)
  );

  always_comb begin
    a_ready  = (r_state == ST_IDLE);
    d_valid  = 1'b0;
    d_opcode = '0;
    d_param  = '0;
    d_size   = '0;
    d_source = '0;
    d_sink   = '0;
    d_data   = '0;
    d_error  = 1'b0;
    if (r_state == ST_RESP) begin
      d_valid  = 1'b1;
      d_opcode = w_isGet ? OPCODE_WIDTH'(TL_ACK_DATA) : OPCODE_WIDTH'(TL_ACK);
      d_size   = r_size;
      d_source = r_source;
      d_error  = !w_legal;
      if (w_isGet && w_legal) d_data = w_rdata;
    end
  end

  assign w_unused = ^{a_param, w_offset[ADDR_WIDTH-1:IDX_W+2], w_offset[1:0]};

endmodule

// File: tb/tb_tlul_sram_slave.sv
// Directed self-checking bench for tlul_sram_slave: puts, gets, partial writes, legality errors,
// response backpressure and reset during an access, all with hand-computed expectations.
`timescale 1ns/1ps
module tb_tlul_sram_slave;

  logic        clk_24 = 1'b0;
  logic        reset;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [2:0]  a_size;
  logic [0:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [2:0]  d_size;
  logic [0:0]  d_source;
  logic [0:0]  d_sink;
  logic [31:0] d_data;
  logic        d_error;

  int checks = 0;
  int errors = 0;

  logic [2:0]  rOp;
  logic        rErr;
  logic [31:0] rData;
  int          lat;

  tlul_sram_slave dut (
    .clk_24    (clk_24),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_opcode  (a_opcode),
    .a_param   (a_param),
    .a_size    (a_size),
    .a_source  (a_source),
    .a_address (a_address),
    .a_mask    (a_mask),
    .a_data    (a_data),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_opcode  (d_opcode),
    .d_param   (d_param),
    .d_size    (d_size),
    .d_source  (d_source),
    .d_sink    (d_sink),
    .d_data    (d_data),
    .d_error   (d_error)
  );

  always #5 clk_24 = ~clk_24;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issues one A request and waits (bounded) for d_valid, leaving d_ready low.
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] sz, input logic [31:0] addr,
                               input logic [3:0] mask, input logic [31:0] data,
                               output logic [2:0] oOp, output logic oErr, output logic [31:0] oData,
                               output int oLat);
    checkOutput("a_ready_before_request", {63'd0, a_ready}, 64'd1);
    a_valid   = 1'b1;
    a_opcode  = op;
    a_size    = sz;
    a_source  = 1'b1;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    @(posedge clk_24); #1;
    a_valid = 1'b0;
    oLat = 0;
    while (!d_valid && oLat < 20) begin
      @(posedge clk_24); #1;
      oLat++;
    end
    oOp   = d_opcode;
    oErr  = d_error;
    oData = d_data;
  endtask

  task automatic finishResponse();
    d_ready = 1'b1;
    @(posedge clk_24); #1;
    d_ready = 1'b0;
    checkOutput("idle_after_d_fire", {62'd0, a_ready, d_valid}, 64'd2);
  endtask

  task automatic runTxn(input string tag, input logic [2:0] op, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                        input logic [2:0] expOp, input logic expErr, input logic [31:0] expData);
    applyStimulus(op, sz, addr, mask, data, rOp, rErr, rData, lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'd3);
    checkOutput({tag, "_opcode"}, {61'd0, rOp}, {61'd0, expOp});
    checkOutput({tag, "_error"}, {63'd0, rErr}, {63'd0, expErr});
    checkOutput({tag, "_data"}, {32'd0, rData}, {32'd0, expData});
    finishResponse();
  endtask

  initial begin
    reset     = 1'b1;
    a_valid   = 1'b0;
    a_opcode  = '0;
    a_param   = 3'd5;
    a_size    = '0;
    a_source  = '0;
    a_address = '0;
    a_mask    = '0;
    a_data    = '0;
    d_ready   = 1'b0;
    repeat (3) @(posedge clk_24);
    #1;
    checkOutput("reset_outputs", {d_valid, a_ready, d_opcode, d_size, d_source, d_error, d_data},
                {1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 32'd0});
    reset = 1'b0;
    @(posedge clk_24); #1;

    runTxn("put_full_w0",   3'd0, 3'd2, 32'h0000_1000, 4'hF, 32'hA5A5_A5A5, 3'd0, 1'b0, 32'h0);
    runTxn("get_w0",        3'd4, 3'd2, 32'h0000_1000, 4'hF, 32'h0,         3'd1, 1'b0, 32'hA5A5_A5A5);
    runTxn("put_full_w1",   3'd0, 3'd2, 32'h0000_1004, 4'hF, 32'h0,         3'd0, 1'b0, 32'h0);
    runTxn("put_part_w1",   3'd1, 3'd2, 32'h0000_1004, 4'h2, 32'h0000_BB00, 3'd0, 1'b0, 32'h0);
    runTxn("get_w1",        3'd4, 3'd2, 32'h0000_1004, 4'hF, 32'h0,         3'd1, 1'b0, 32'h0000_BB00);
    runTxn("put_part_b0",   3'd1, 3'd2, 32'h0000_1004, 4'h1, 32'hFFFF_FFCC, 3'd0, 1'b0, 32'h0);
    runTxn("get_w1_again",  3'd4, 3'd2, 32'h0000_1004, 4'hF, 32'h0,         3'd1, 1'b0, 32'h0000_BBCC);
    runTxn("get_w0_intact", 3'd4, 3'd2, 32'h0000_1000, 4'hF, 32'h0,         3'd1, 1'b0, 32'hA5A5_A5A5);
    runTxn("put_byte1",     3'd0, 3'd0, 32'h0000_1001, 4'h2, 32'h0000_5A00, 3'd0, 1'b0, 32'h0);
    runTxn("get_byte_merge",3'd4, 3'd2, 32'h0000_1000, 4'hF, 32'h0,         3'd1, 1'b0, 32'hA5A5_5AA5);
    runTxn("put_bad_mask",  3'd0, 3'd0, 32'h0000_1001, 4'h1, 32'h0000_0011, 3'd0, 1'b1, 32'h0);
    runTxn("put_last_word", 3'd0, 3'd2, 32'h0000_1FFC, 4'hF, 32'h1234_5678, 3'd0, 1'b0, 32'h0);
    runTxn("get_last_word", 3'd4, 3'd2, 32'h0000_1FFC, 4'hF, 32'h0,         3'd1, 1'b0, 32'h1234_5678);
    runTxn("get_below_base",3'd4, 3'd2, 32'h0000_0FFC, 4'hF, 32'h0,         3'd1, 1'b1, 32'h0);
    runTxn("get_past_end",  3'd4, 3'd2, 32'h0000_2000, 4'hF, 32'h0,         3'd1, 1'b1, 32'h0);
    runTxn("put_misaligned",3'd0, 3'd2, 32'h0000_1002, 4'hF, 32'hDEAD_BEEF, 3'd0, 1'b1, 32'h0);
    runTxn("bad_opcode",    3'd3, 3'd2, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF, 3'd0, 1'b1, 32'h0);
    runTxn("put_part_extra",3'd1, 3'd1, 32'h0000_1000, 4'h4, 32'h00FF_0000, 3'd0, 1'b1, 32'h0);
    runTxn("put_part_zero", 3'd1, 3'd2, 32'h0000_1000, 4'h0, 32'hFFFF_FFFF, 3'd0, 1'b0, 32'h0);
    runTxn("get_unchanged", 3'd4, 3'd2, 32'h0000_1000, 4'hF, 32'h0,         3'd1, 1'b0, 32'hA5A5_5AA5);

    // Backpressure: response must hold steady while d_ready stays low.
    applyStimulus(3'd4, 3'd2, 32'h0000_1FFC, 4'hF, 32'h0, rOp, rErr, rData, lat);
    checkOutput("stall_latency", 64'(lat), 64'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_24); #1;
      checkOutput("stall_response", {d_valid, a_ready, d_opcode, d_size, d_source, d_error, d_data},
                  {1'b1, 1'b0, 3'd1, 3'd2, 1'b1, 1'b0, 32'h1234_5678});
    end
    finishResponse();

    // Reset lands on the commit edge of a put: the write must be discarded.
    a_valid   = 1'b1;
    a_opcode  = 3'd0;
    a_size    = 3'd2;
    a_address = 32'h0000_1000;
    a_mask    = 4'hF;
    a_data    = 32'hDEAD_BEEF;
    @(posedge clk_24); #1;
    a_valid = 1'b0;
    repeat (2) @(posedge clk_24);
    #1;
    checkOutput("access_before_reset", {62'd0, a_ready, d_valid}, 64'd0);
    reset = 1'b1;
    @(posedge clk_24); #1;
    reset = 1'b0;
    checkOutput("reset_abort", {62'd0, a_ready, d_valid}, 64'd2);
    @(posedge clk_24); #1;
    checkOutput("after_release", {62'd0, a_ready, d_valid}, 64'd2);
    runTxn("get_after_reset", 3'd4, 3'd2, 32'h0000_1000, 4'hF, 32'h0, 3'd1, 1'b0, 32'hA5A5_5AA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
